transform_shift_pipe: RTL and testbench

Pipelined, multi-channel successor to the combinational transform shift calculator in the RDOQ front end. It holds per-channel coding configuration (bit depth, dynamic range, extended precision) in registers. Per-TU requests arrive on a valid/ready stream; for each, the block returns the signed transform shift plus derived right/left shift magnitudes and a rounding offset. It sits between the TU scheduler and the quantiser datapath at one request per cycle.

---
 rtl/transform_shift_pkg.sv | 41 ++++
 rtl/rdoq_pipe_reg.sv | 41 ++++
 rtl/transform_shift_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_transform_shift_pipe.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transform_shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | transform_shift_pkg                                                        |
// | Shared widths, per-channel config type and result type for the pipeline.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package transform_shift_pkg;

    localparam int TS_BD_W    = 4;
    localparam int TS_DR_W    = 5;
    localparam int TS_LOG2_W  = 3;
    localparam int TS_SHIFT_W = 6;

    localparam int CFG_BD_RST = 8;
    localparam int CFG_DR_RST = 15;

    typedef struct packed {
        logic [TS_BD_W-1:0] bit_depth;
        logic [TS_DR_W-1:0] max_dr;
        logic               ext_prec;
    } cfg_t;

    typedef struct packed {
        logic [TS_SHIFT_W-1:0] shift;
        logic [TS_SHIFT_W-2:0] rshift;
        logic [TS_SHIFT_W-2:0] lshift;
        logic                  clamped;
        logic                  sat;
        logic                  err;
    } res_t;

    function automatic cfg_t cfg_reset_value();
        cfg_t c;
        c.bit_depth = TS_BD_W'(CFG_BD_RST);
        c.max_dr    = TS_DR_W'(CFG_DR_RST);
        c.ext_prec  = 1'b0;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rdoq_pipe_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rdoq_pipe_reg                                                              |
// | One-entry valid/ready pipeline register carrying an arbitrary payload type.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rdoq_pipe_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic valid_q;
    T     data_q;

    // Payload only loads on an accepted beat so it stays frozen while stalled.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/transform_shift_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | transform_shift_pipe                                                       |
// | Two-stage per-channel transform shift / rounding offset calculator.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module transform_shift_pipe
    import transform_shift_pkg::*;
#(
    parameter  int NUM_CH   = 3,
    parameter  int LOG2_MIN = 2,
    parameter  int LOG2_MAX = 5,
    parameter  int OFF_W    = 32,
    parameter  int TAG_W    = 8,
    localparam int BD_W     = TS_BD_W,
    localparam int DR_W     = TS_DR_W,
    localparam int LOG2_W   = TS_LOG2_W,
    localparam int SHIFT_W  = TS_SHIFT_W,
    localparam int CH_W     = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [BD_W-1:0]           cfg_bit_depth,
    input  logic [DR_W-1:0]           cfg_max_dr,
    input  logic                      cfg_ext_prec,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH_W-1:0]           in_ch,
    input  logic [LOG2_W-1:0]         in_log2_size,
    input  logic                      in_ts,
    input  logic [TAG_W-1:0]          in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [SHIFT_W-1:0] out_shift,
    output logic [SHIFT_W-2:0]        out_rshift,
    output logic [SHIFT_W-2:0]        out_lshift,
    output logic [OFF_W-1:0]          out_round_offset,
    output logic                      out_clamped,
    output logic                      out_sat,
    output logic                      out_err,
    output logic [TAG_W-1:0]          out_tag,
    output logic [15:0]               clamp_count
);

    localparam logic signed [SHIFT_W+1:0] C_SMAX  = (SHIFT_W+2)'(2**(SHIFT_W-1) - 1);
    localparam logic signed [SHIFT_W+1:0] C_SMIN  = -(SHIFT_W+2)'(2**(SHIFT_W-1));
    localparam logic [31:0]               C_OFF_W = 32'(OFF_W);
    localparam logic [SHIFT_W-2:0]        C_ONE   = (SHIFT_W-1)'(1);

    typedef struct packed {
        cfg_t               cfg;
        logic               err;
        logic [LOG2_W-1:0]  log2;
        logic               ts;
        logic [TAG_W-1:0]   tag;
    } s1_t;

    typedef struct packed {
        res_t               res;
        logic [OFF_W-1:0]   off;
        logic [TAG_W-1:0]   tag;
    } s2_t;

    cfg_t cfg_q [NUM_CH];
    cfg_t cfg_wr;
    cfg_t cfg_sel;
    logic rst_done_q;
    logic [15:0] clamp_cnt_q;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic s1_in_ready, s1_valid, s2_in_ready;

    logic signed [SHIFT_W+1:0] base;
    logic signed [SHIFT_W-1:0] sh;
    logic [SHIFT_W-1:0]        mag;

    assign cfg_wr.bit_depth = cfg_bit_depth;
    assign cfg_wr.max_dr    = cfg_max_dr;
    assign cfg_wr.ext_prec  = cfg_ext_prec;

    // Writes to a channel index beyond NUM_CH match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cfg_q[i] <= cfg_reset_value();
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_ch == CH_W'(i)) begin
                    cfg_q[i] <= cfg_wr;
                end
            end
        end
    end

    always_comb begin
        cfg_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch == CH_W'(i)) begin
                cfg_sel = cfg_q[i];
            end
        end
    end

    // Holds in_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    always_comb begin
        s1_d      = '0;
        s1_d.cfg  = cfg_sel;
        s1_d.err  = ({1'b0, in_ch} >= (CH_W+1)'(NUM_CH))
                 || (in_log2_size < LOG2_W'(LOG2_MIN))
                 || (in_log2_size > LOG2_W'(LOG2_MAX));
        s1_d.log2 = in_log2_size;
        s1_d.ts   = in_ts;
        s1_d.tag  = in_tag;
    end

    assign in_ready = rst_done_q && s1_in_ready;

    rdoq_pipe_reg #(.T(s1_t)) u_s1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid && rst_done_q),
        .in_ready_o  (s1_in_ready),
        .in_data_i   (s1_d),
        .out_valid_o (s1_valid),
        .out_ready_i (s2_in_ready),
        .out_data_o  (s1_q)
    );

    always_comb begin
        base = $signed((SHIFT_W+2)'(s1_q.cfg.max_dr))
             - $signed((SHIFT_W+2)'(s1_q.cfg.bit_depth))
             - $signed((SHIFT_W+2)'(s1_q.log2));
        sh       = '0;
        mag      = '0;
        s2_d     = '0;
        s2_d.tag = s1_q.tag;
        if (s1_q.err) begin
            s2_d.res.err = 1'b1;
        end else begin
            if (s1_q.ts && s1_q.cfg.ext_prec && base[SHIFT_W+1]) begin
                s2_d.res.clamped = 1'b1;
            end else if (base > C_SMAX) begin
                sh           = C_SMAX[SHIFT_W-1:0];
                s2_d.res.sat = 1'b1;
            end else if (base < C_SMIN) begin
                sh           = C_SMIN[SHIFT_W-1:0];
                s2_d.res.sat = 1'b1;
            end else begin
                sh = base[SHIFT_W-1:0];
            end
            s2_d.res.shift = sh;
            if (sh[SHIFT_W-1]) begin
                // The most negative shift has no magnitude encoding; it is already flagged sat.
                mag             = -sh;
                s2_d.res.lshift = mag[SHIFT_W-1] ? '1 : mag[SHIFT_W-2:0];
            end else begin
                s2_d.res.rshift = sh[SHIFT_W-2:0];
            end
            if (s2_d.res.rshift != '0) begin
                if (32'(s2_d.res.rshift) > C_OFF_W) begin
                    s2_d.res.sat = 1'b1;
                end else begin
                    s2_d.off = OFF_W'(1) << (s2_d.res.rshift - C_ONE);
                end
            end
        end
    end

    rdoq_pipe_reg #(.T(s2_t)) u_s2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (s1_valid),
        .in_ready_o  (s2_in_ready),
        .in_data_i   (s2_d),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (s2_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clamp_cnt_q <= '0;
        end else if (out_valid && out_ready && s2_q.res.clamped && (clamp_cnt_q != 16'hFFFF)) begin
            clamp_cnt_q <= clamp_cnt_q + 16'd1;
        end
    end

    assign out_shift        = s2_q.res.shift;
    assign out_rshift       = s2_q.res.rshift;
    assign out_lshift       = s2_q.res.lshift;
    assign out_round_offset = s2_q.off;
    assign out_clamped      = s2_q.res.clamped;
    assign out_sat          = s2_q.res.sat;
    assign out_err          = s2_q.res.err;
    assign out_tag          = s2_q.tag;
    assign clamp_count      = clamp_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_transform_shift_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_transform_shift_pipe                                                    |
// | Directed scoreboard bench for transform_shift_pipe (OFF_W = 16 instance).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_transform_shift_pipe;

    localparam int NUM_CH = 3;
    localparam int OFF_W  = 16;

    typedef struct packed {
        logic [5:0]  shift;
        logic [4:0]  rs;
        logic [4:0]  ls;
        logic [15:0] off;
        logic        cl;
        logic        sat;
        logic        err;
        logic [7:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cfg_we = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [3:0] cfg_bit_depth = '0;
    logic [4:0] cfg_max_dr = '0;
    logic cfg_ext_prec = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [1:0] in_ch = '0;
    logic [2:0] in_log2_size = '0;
    logic in_ts = 1'b0;
    logic [7:0] in_tag = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [5:0] out_shift;
    logic [4:0] out_rshift, out_lshift;
    logic [15:0] out_round_offset;
    logic out_clamped, out_sat, out_err;
    logic [7:0] out_tag;
    logic [15:0] clamp_count;

    exp_t sb[$];
    exp_t mon_e;
    exp_t e_c;
    int   m_bd [NUM_CH];
    int   m_dr [NUM_CH];
    int   m_ep [NUM_CH];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    transform_shift_pipe #(
        .NUM_CH   (NUM_CH),
        .LOG2_MIN (2),
        .LOG2_MAX (5),
        .OFF_W    (OFF_W),
        .TAG_W    (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_we           (cfg_we),
        .cfg_ch           (cfg_ch),
        .cfg_bit_depth    (cfg_bit_depth),
        .cfg_max_dr       (cfg_max_dr),
        .cfg_ext_prec     (cfg_ext_prec),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_ch            (in_ch),
        .in_log2_size     (in_log2_size),
        .in_ts            (in_ts),
        .in_tag           (in_tag),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_shift        (out_shift),
        .out_rshift       (out_rshift),
        .out_lshift       (out_lshift),
        .out_round_offset (out_round_offset),
        .out_clamped      (out_clamped),
        .out_sat          (out_sat),
        .out_err          (out_err),
        .out_tag          (out_tag),
        .clamp_count      (clamp_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int ch, input int l2, input int ts, input int tag);
        exp_t e;
        int base, sh;
        e = '0;
        e.tag = 8'(tag);
        if (ch >= NUM_CH || l2 < 2 || l2 > 5) begin
            e.err = 1'b1;
            return e;
        end
        base = m_dr[ch] - m_bd[ch] - l2;
        if (ts != 0 && m_ep[ch] != 0 && base < 0) begin
            e.cl = 1'b1;
            sh   = 0;
        end else begin
            sh = base;
            if (sh > 31)  begin sh = 31;  e.sat = 1'b1; end
            if (sh < -32) begin sh = -32; e.sat = 1'b1; end
        end
        e.shift = 6'(sh);
        if (sh > 0) begin
            e.rs = 5'(sh);
            if (sh <= OFF_W) e.off = 16'(1 << (sh - 1));
            else             e.sat = 1'b1;
        end
        if (sh < 0) e.ls = (sh == -32) ? 5'd31 : 5'(-sh);
        return e;
    endfunction

    task automatic reset_mirror();
        for (int i = 0; i < NUM_CH; i++) begin
            m_bd[i] = 8;
            m_dr[i] = 15;
            m_ep[i] = 0;
        end
    endtask

    task automatic write_cfg(input int ch, input int bd, input int dr, input int ep);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_bit_depth = 4'(bd); cfg_max_dr = 5'(dr); cfg_ext_prec = 1'(ep);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (ch < NUM_CH) begin
            m_bd[ch] = bd; m_dr[ch] = dr; m_ep[ch] = ep;
        end
    endtask

    task automatic send(input int ch, input int l2, input int ts, input int tag);
        exp_t e;
        bit ok;
        ok = 1'b0;
        e  = model(ch, l2, ts, tag);
        in_valid = 1'b1; in_ch = 2'(ch); in_log2_size = 3'(l2); in_ts = 1'(ts); in_tag = 8'(tag);
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("accept", 32'(ok), 32'd1);
        if (ok) sb.push_back(e);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && sb.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("out_tag",     32'(out_tag),              32'(mon_e.tag));
                chk("out_shift",   32'($unsigned(out_shift)), 32'(mon_e.shift));
                chk("out_rshift",  32'(out_rshift),           32'(mon_e.rs));
                chk("out_lshift",  32'(out_lshift),           32'(mon_e.ls));
                chk("out_offset",  32'(out_round_offset),     32'(mon_e.off));
                chk("out_clamped", 32'(out_clamped),          32'(mon_e.cl));
                chk("out_sat",     32'(out_sat),              32'(mon_e.sat));
                chk("out_err",     32'(out_err),              32'(mon_e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_mirror();
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid",   32'(out_valid),              32'd0);
        chk("rst_in_ready",    32'(in_ready),               32'd0);
        chk("rst_clamp_count", 32'(clamp_count),            32'd0);
        chk("rst_out_shift",   32'($unsigned(out_shift)),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Defaults, channel 0, latency of two register stages
        send(0, 5, 0, 8'h10);
        chk("lat_stage1_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_stage2_valid", 32'(out_valid),              32'd1);
        chk("lat_shift",        32'($unsigned(out_shift)),   32'd2);
        chk("lat_offset",       32'(out_round_offset),       32'd2);
        drain();

        // Transform-skip clamp with extended precision, then without
        write_cfg(1, 12, 15, 1);
        send(1, 5, 1, 8'h20);
        drain();
        chk("clamp_count_one", 32'(clamp_count), 32'd1);
        write_cfg(1, 12, 15, 0);
        send(1, 5, 1, 8'h21);
        drain();
        chk("clamp_count_hold", 32'(clamp_count), 32'd1);

        // Offset saturation boundary and illegal requests kept in order
        write_cfg(2, 0, 31, 0);
        send(2, 2, 0, 8'h30);
        write_cfg(2, 0, 18, 0);
        send(2, 2, 0, 8'h31);
        write_cfg(2, 0, 19, 0);
        send(2, 2, 0, 8'h32);
        send(3, 4, 0, 8'h33);
        send(0, 6, 0, 8'h34);
        send(0, 1, 0, 8'h35);
        send(0, 2, 0, 8'h36);
        drain();

        // Config write to a nonexistent channel must not disturb channel 0
        write_cfg(3, 1, 1, 1);
        send(0, 3, 0, 8'h37);
        drain();

        // Backpressure: two fill the pipe, third is refused until release
        out_ready = 1'b0;
        send(0, 5, 0, 8'h40);
        send(1, 4, 1, 8'h41);
        e_c = model(2, 3, 0, 8'h42);
        in_valid = 1'b1; in_ch = 2'd2; in_log2_size = 3'd3; in_ts = 1'b0; in_tag = 8'h42;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready",  32'(in_ready),              32'd0);
            chk("stall_out_valid", 32'(out_valid),             32'd1);
            chk("stall_out_tag",   32'(out_tag),               32'(sb[0].tag));
            chk("stall_out_shift", 32'($unsigned(out_shift)),  32'(sb[0].shift));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready),  32'd1);
        chk("drain_beat0",      32'(out_valid), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(e_c);
        @(negedge clk);
        chk("drain_beat1", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_beat2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("drain_done_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("stall_sb_empty", 32'(sb.size()), 32'd0);

        // Config write racing a request on the same channel
        cfg_bit_depth = 4'd10; cfg_max_dr = 5'd15; cfg_ext_prec = 1'b0; cfg_ch = 2'd0; cfg_we = 1'b1;
        send(0, 4, 0, 8'h50);
        cfg_we = 1'b0;
        m_bd[0] = 10;
        send(0, 4, 0, 8'h51);
        drain();

        // Mixed random requests at full rate
        for (int i = 0; i < 12; i++) begin
            send(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                 int'($urandom_range(0, 1)), 8'h60 + i);
        end
        drain();

        // Asynchronous reset with two results in flight
        out_ready = 1'b0;
        send(1, 5, 1, 8'h70);
        send(0, 5, 0, 8'h71);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid",   32'(out_valid),   32'd0);
        chk("midrst_in_ready",    32'(in_ready),    32'd0);
        chk("midrst_clamp_count", 32'(clamp_count), 32'd0);
        chk("midrst_out_tag",     32'(out_tag),     32'd0);
        sb.delete();
        reset_mirror();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(0, 5, 0, 8'h72);
        send(1, 5, 1, 8'h73);
        send(2, 2, 0, 8'h74);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
